naxi_arb_2x1: RTL and testbench
===============================

# naxi_arb_2x1

Two-master to one-slave NAXI arbiter placed between CPU-side masters and the single L2 cache NAXI slave port. It shares the command channel round-robin, keeps the write-data channel in command order, and routes read responses back by an appended source ID bit. State consists of the round-robin pointer, the write-order FIFO and the write beat counter. All other paths are combinational pass-through.

## Interface
- NXADDRWIDTH, 31, address width
- NXDATAWIDTH, 256, data width
- NXIDWIDTH, 4, upstream ID width; downstream ID is NXIDWIDTH+1
- NXTYPEWIDTH, 3, command type width
- NXSIZEWIDTH, 8, burst size; write burst = size+1 beats
- NXATTRWIDTH, 3, attribute width
- TYPEWR, 1, creq_type value that marks a write; every other value is a read
- WRQDPTH, 4, write-order FIFO depth
- BITWRQD, 2, log2(WRQDPTH)

Ports (N = 0,1; every port exists as m0_* and m1_*):
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-low reset
- mN_creq_valid/type/attr/size/id/addr  in  1/TYPE/ATTR/SIZE/ID/ADDR  master command
- mN_creq_rdstall, mN_creq_wrstall  out  1  read/write command backpressure to master
- mN_dreq_valid/id/data/attr  in  1/ID/DATA/ATTR  master write data
- mN_dreq_stall  out  1  write-data backpressure
- mN_rreq_valid/id/data/attr  out  1/ID/DATA/ATTR  response to master
- mN_rreq_stall  in  1  response backpressure from master
- s_creq_valid/type/attr/size/addr  out  command to slave
- s_creq_id  out  NXIDWIDTH+1  {src, mN_creq_id}
- s_creq_rdstall, s_creq_wrstall  in  1  slave command backpressure
- s_dreq_valid/data/attr  out  write data to slave
- s_dreq_id  out  NXIDWIDTH+1  {src, mN_dreq_id}
- s_dreq_stall  in  1
- s_rreq_valid/data/attr  in  response from slave
- s_rreq_id  in  NXIDWIDTH+1  bit [NXIDWIDTH] selects the master
- s_rreq_stall  out  1

## Operation
- A transfer happens in any cycle with valid=1 and the applicable stall=0. A write command uses wrstall; a read command uses rdstall. Stall inputs must not depend combinationally on valid.
- Command arbitration:
  - Grant goes to the single requesting master.
  - When both request, grant goes to the master named by rr_ptr.
  - rr_ptr becomes ~src after each accepted command. It holds when no command is accepted.
  - Reset value of rr_ptr is 0.
- Grant is combinational and held while the granted master stays valid and stalled. Masters must hold the command stable until it is accepted.
- Command stalls:
  - mN_creq_rdstall = !gntN | s_creq_rdstall.
  - mN_creq_wrstall = !gntN | s_creq_wrstall | wfifo_full.
  - s_creq_valid = the granted master's valid. When the granted command is a write and the FIFO is full, s_creq_valid is forced to 0.
- Write-order FIFO:
  - Pushes {src, size} on each accepted write command.
  - Pops when the last beat of the head burst is accepted.
  - When a push and a pop happen in the same cycle while full, the push is still blocked, because full gates it combinationally.
- Data channel:
  - While the FIFO is non-empty, the head's src master is connected to s_dreq and the other master's dreq_stall is 1.
  - When the FIFO is empty, both dreq_stall are 1 and s_dreq_valid is 0.
  - beat_cnt (NXSIZEWIDTH bits) increments on each accepted beat. When beat_cnt == head.size, the beat is last: beat_cnt clears and the FIFO pops.
  - Write data may be accepted in the same cycle as its own command only after the command has been pushed, so the earliest data beat is the cycle after command acceptance.
- Response routing:
  - s_rreq_id[NXIDWIDTH] = k drives mk_rreq_valid, with id = s_rreq_id[NXIDWIDTH-1:0].
  - s_rreq_stall = mk_rreq_stall. The other master's rreq_valid is 0.
- Reset (rst=0), asynchronous:
  - Clears rr_ptr, the FIFO pointers and beat_cnt.
  - Forces s_creq_valid, s_dreq_valid and mN_rreq_valid to 0.
  - Forces all mN_*stall and s_rreq_stall to 1.
  - A burst in flight at reset is dropped.

## Timing
- Command, data and response paths have zero latency (combinational). Only accepted transfers advance state, at the next rising edge.
- Round-robin fairness: with both masters continuously valid, grants alternate every accepted command.
- FIFO full at WRQDPTH outstanding un-drained write bursts. Pointers are BITWRQD+1 bits, which handles wrap.
- Reset deassertion: the first command can be accepted in the first cycle after rst rises.

## Test plan
- Both masters issue continuous reads with the slave never stalled:
  - Grants go m0, m1, m0, m1…
  - s_creq_id MSB alternates 0,1,0,1.
- m1 write with size=3 (4 beats), then m0 write with size=0:
  - s_dreq carries m1's 4 beats, then m0's 1 beat.
  - m0_dreq_stall stays 1 until m1's 4th beat is accepted.
- Five back-to-back writes from m0 with dreq withheld:
  - The 5th command sees m0_creq_wrstall=1. s_creq_valid=0.
  - After one burst drains, the 5th command is accepted.
- Slave returns a response with s_rreq_id=5'b1_0110 while m1_rreq_stall=1 for 3 cycles:
  - m1_rreq_valid=1 with id 4'b0110, s_rreq_stall=1 for those 3 cycles, then transfer.
  - m0_rreq_valid=0 throughout.
- s_creq_rdstall=1 with s_creq_wrstall=0, m0 read and m1 write pending, rr_ptr=0:
  - m0 is held.
  - rr_ptr stays 0 and no command transfers until rdstall drops.
- rst pulled low mid-burst (beat 2 of 4):
  - All valids go to 0 and all stalls to 1 immediately.
  - After release, the FIFO is empty and rr_ptr=0.

Source files
------------

// File: rtl/naxi_arb_2x1.sv
// naxi_arb_2x1
// Two-master to one-slave NAXI arbiter sitting in front of the L2 cache slave
// port.
//  - Command channel: shared round-robin between m0 and m1. The winning
//    master's index is prepended to the downstream ID.
//  - Write-data channel: a small FIFO remembers {src, size} for every accepted
//    write command. The data channel serves bursts strictly in command order.
//  - Response channel: the slave's ID MSB steers the response to m0 or m1.
// Ports:
//  clk, rst                   clock, asynchronous active-low reset
//  mN_creq_*                  master N command in; rdstall/wrstall out
//  mN_dreq_*                  master N write data in; dreq_stall out
//  mN_rreq_*                  master N response out; rreq_stall in
//  s_creq_*                   command to slave; rdstall/wrstall in
//  s_dreq_*                   write data to slave; dreq_stall in
//  s_rreq_*                   response from slave; rreq_stall out
// All data paths are combinational. Only rr_ptr, the write-order FIFO and the
// beat counter are registered.
module naxi_arb_2x1 #(
   parameter int NXADDRWIDTH = 31,
   parameter int NXDATAWIDTH = 256,
   parameter int NXIDWIDTH   = 4,
   parameter int NXTYPEWIDTH = 3,
   parameter int NXSIZEWIDTH = 8,
   parameter int NXATTRWIDTH = 3,
   parameter int TYPEWR      = 1,
   parameter int WRQDPTH     = 4,
   parameter int BITWRQD     = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   // master 0
   input  logic                   m0_creq_valid,
   input  logic [NXTYPEWIDTH-1:0] m0_creq_type,
   input  logic [NXATTRWIDTH-1:0] m0_creq_attr,
   input  logic [NXSIZEWIDTH-1:0] m0_creq_size,
   input  logic [NXIDWIDTH-1:0]   m0_creq_id,
   input  logic [NXADDRWIDTH-1:0] m0_creq_addr,
   output logic                   m0_creq_rdstall,
   output logic                   m0_creq_wrstall,
   input  logic                   m0_dreq_valid,
   input  logic [NXIDWIDTH-1:0]   m0_dreq_id,
   input  logic [NXDATAWIDTH-1:0] m0_dreq_data,
   input  logic [NXATTRWIDTH-1:0] m0_dreq_attr,
   output logic                   m0_dreq_stall,
   output logic                   m0_rreq_valid,
   output logic [NXIDWIDTH-1:0]   m0_rreq_id,
   output logic [NXDATAWIDTH-1:0] m0_rreq_data,
   output logic [NXATTRWIDTH-1:0] m0_rreq_attr,
   input  logic                   m0_rreq_stall,
   // master 1
   input  logic                   m1_creq_valid,
   input  logic [NXTYPEWIDTH-1:0] m1_creq_type,
   input  logic [NXATTRWIDTH-1:0] m1_creq_attr,
   input  logic [NXSIZEWIDTH-1:0] m1_creq_size,
   input  logic [NXIDWIDTH-1:0]   m1_creq_id,
   input  logic [NXADDRWIDTH-1:0] m1_creq_addr,
   output logic                   m1_creq_rdstall,
   output logic                   m1_creq_wrstall,
   input  logic                   m1_dreq_valid,
   input  logic [NXIDWIDTH-1:0]   m1_dreq_id,
   input  logic [NXDATAWIDTH-1:0] m1_dreq_data,
   input  logic [NXATTRWIDTH-1:0] m1_dreq_attr,
   output logic                   m1_dreq_stall,
   output logic                   m1_rreq_valid,
   output logic [NXIDWIDTH-1:0]   m1_rreq_id,
   output logic [NXDATAWIDTH-1:0] m1_rreq_data,
   output logic [NXATTRWIDTH-1:0] m1_rreq_attr,
   input  logic                   m1_rreq_stall,
   // slave
   output logic                   s_creq_valid,
   output logic [NXTYPEWIDTH-1:0] s_creq_type,
   output logic [NXATTRWIDTH-1:0] s_creq_attr,
   output logic [NXSIZEWIDTH-1:0] s_creq_size,
   output logic [NXIDWIDTH:0]     s_creq_id,
   output logic [NXADDRWIDTH-1:0] s_creq_addr,
   input  logic                   s_creq_rdstall,
   input  logic                   s_creq_wrstall,
   output logic                   s_dreq_valid,
   output logic [NXIDWIDTH:0]     s_dreq_id,
   output logic [NXDATAWIDTH-1:0] s_dreq_data,
   output logic [NXATTRWIDTH-1:0] s_dreq_attr,
   input  logic                   s_dreq_stall,
   input  logic                   s_rreq_valid,
   input  logic [NXIDWIDTH:0]     s_rreq_id,
   input  logic [NXDATAWIDTH-1:0] s_rreq_data,
   input  logic [NXATTRWIDTH-1:0] s_rreq_attr,
   output logic                   s_rreq_stall
);

   localparam logic [NXTYPEWIDTH-1:0] TYPE_WR  = NXTYPEWIDTH'(TYPEWR);
   localparam logic [NXSIZEWIDTH-1:0] BEAT_ONE = NXSIZEWIDTH'(32'd1);
   localparam logic [BITWRQD:0]       PTR_ONE  = (BITWRQD+1)'(32'd1);

   // Arbitration state and write-order FIFO ({src, size} per entry).
   // The pointers carry one extra wrap bit so full and empty can be told apart.
   logic                   rr_ptr_r;
   logic [BITWRQD:0]       wr_ptr_r;
   logic [BITWRQD:0]       rd_ptr_r;
   logic [NXSIZEWIDTH-1:0] beat_cnt_r;
   logic [NXSIZEWIDTH:0]   wfifo_r [WRQDPTH];

   logic                   src_s;
   logic                   gnt0_s;
   logic                   gnt1_s;
   logic                   sel_valid_s;
   logic [NXTYPEWIDTH-1:0] sel_type_s;
   logic [NXSIZEWIDTH-1:0] sel_size_s;
   logic [NXIDWIDTH-1:0]   sel_id_s;
   logic                   sel_wr_s;
   logic                   wfifo_full_s;
   logic                   wfifo_empty_s;
   logic                   cmd_acc_s;
   logic                   push_s;
   logic [NXSIZEWIDTH:0]   head_s;
   logic                   head_src_s;
   logic [NXSIZEWIDTH-1:0] head_size_s;
   logic                   dreq_acc_s;
   logic                   last_beat_s;
   logic                   pop_s;
   logic                   rsp_src_s;

   // Command source: a lone requester wins; on contention rr_ptr decides.
   always_comb begin
      src_s = rr_ptr_r;
      if (m0_creq_valid && !m1_creq_valid) begin
         src_s = 1'b0;
      end else if (m1_creq_valid && !m0_creq_valid) begin
         src_s = 1'b1;
      end else begin
         src_s = rr_ptr_r;
      end
   end

   assign gnt0_s      = m0_creq_valid && !src_s;
   assign gnt1_s      = m1_creq_valid &&  src_s;
   assign sel_valid_s = src_s ? m1_creq_valid : m0_creq_valid;
   assign sel_type_s  = src_s ? m1_creq_type  : m0_creq_type;
   assign sel_size_s  = src_s ? m1_creq_size  : m0_creq_size;
   assign sel_id_s    = src_s ? m1_creq_id    : m0_creq_id;
   assign sel_wr_s    = (sel_type_s == TYPE_WR);

   assign wfifo_empty_s = (wr_ptr_r == rd_ptr_r);
   assign wfifo_full_s  = (wr_ptr_r[BITWRQD] != rd_ptr_r[BITWRQD]) &&
                          (wr_ptr_r[BITWRQD-1:0] == rd_ptr_r[BITWRQD-1:0]);

   // A write is withheld from the slave while the order FIFO cannot record it.
   assign s_creq_valid = rst && sel_valid_s && !(sel_wr_s && wfifo_full_s);
   assign s_creq_type  = sel_type_s;
   assign s_creq_size  = sel_size_s;
   assign s_creq_id    = {src_s, sel_id_s};
   assign s_creq_attr  = src_s ? m1_creq_attr : m0_creq_attr;
   assign s_creq_addr  = src_s ? m1_creq_addr : m0_creq_addr;

   assign m0_creq_rdstall = !rst || !gnt0_s || s_creq_rdstall;
   assign m1_creq_rdstall = !rst || !gnt1_s || s_creq_rdstall;
   assign m0_creq_wrstall = !rst || !gnt0_s || s_creq_wrstall || wfifo_full_s;
   assign m1_creq_wrstall = !rst || !gnt1_s || s_creq_wrstall || wfifo_full_s;

   assign cmd_acc_s = s_creq_valid && (sel_wr_s ? !s_creq_wrstall : !s_creq_rdstall);
   assign push_s    = cmd_acc_s && sel_wr_s;

   // Data channel follows the FIFO head; an empty FIFO blocks both masters, so
   // a burst can start no earlier than the cycle after its command.
   assign head_s      = wfifo_r[rd_ptr_r[BITWRQD-1:0]];
   assign head_src_s  = head_s[NXSIZEWIDTH];
   assign head_size_s = head_s[NXSIZEWIDTH-1:0];

   assign s_dreq_valid = rst && !wfifo_empty_s && (head_src_s ? m1_dreq_valid : m0_dreq_valid);
   assign s_dreq_id    = {head_src_s, (head_src_s ? m1_dreq_id : m0_dreq_id)};
   assign s_dreq_data  = head_src_s ? m1_dreq_data : m0_dreq_data;
   assign s_dreq_attr  = head_src_s ? m1_dreq_attr : m0_dreq_attr;

   assign m0_dreq_stall = !rst || wfifo_empty_s ||  head_src_s || s_dreq_stall;
   assign m1_dreq_stall = !rst || wfifo_empty_s || !head_src_s || s_dreq_stall;

   assign dreq_acc_s  = s_dreq_valid && !s_dreq_stall;
   assign last_beat_s = (beat_cnt_r == head_size_s);
   assign pop_s       = dreq_acc_s && last_beat_s;

   // Response routing by the ID MSB appended on the command path.
   assign rsp_src_s     = s_rreq_id[NXIDWIDTH];
   assign m0_rreq_valid = rst && s_rreq_valid && !rsp_src_s;
   assign m1_rreq_valid = rst && s_rreq_valid &&  rsp_src_s;
   assign m0_rreq_id    = s_rreq_id[NXIDWIDTH-1:0];
   assign m1_rreq_id    = s_rreq_id[NXIDWIDTH-1:0];
   assign m0_rreq_data  = s_rreq_data;
   assign m1_rreq_data  = s_rreq_data;
   assign m0_rreq_attr  = s_rreq_attr;
   assign m1_rreq_attr  = s_rreq_attr;
   assign s_rreq_stall  = !rst || (rsp_src_s ? m1_rreq_stall : m0_rreq_stall);

   // Round-robin pointer: the loser of the last accepted command goes next.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rr_ptr_r <= 1'b0;
      end else if (cmd_acc_s) begin
         rr_ptr_r <= ~src_s;
      end
   end

   // FIFO pointers; push is already gated by full through s_creq_valid.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
      end
   end

   // FIFO storage.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < WRQDPTH; i++) begin
            wfifo_r[i] <= '0;
         end
      end else if (push_s) begin
         wfifo_r[wr_ptr_r[BITWRQD-1:0]] <= {src_s, sel_size_s};
      end
   end

   // Beat counter within the head burst; clears on the last beat.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         beat_cnt_r <= '0;
      end else if (dreq_acc_s) begin
         if (last_beat_s) begin
            beat_cnt_r <= '0;
         end else begin
            beat_cnt_r <= beat_cnt_r + BEAT_ONE;
         end
      end
   end

endmodule

// File: tb/tb_naxi_arb_2x1.sv
// Self-checking bench for naxi_arb_2x1: random traffic on all three channels,
// compared each cycle against a queue-based reference model of the arbiter.
module tb_naxi_arb_2x1;
   localparam int AW = 31, DW = 256, IW = 4, TW = 3, SW = 8, ATW = 3;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic m0_creq_valid, m1_creq_valid;
   logic [TW-1:0]  m0_creq_type, m1_creq_type;
   logic [ATW-1:0] m0_creq_attr, m1_creq_attr;
   logic [SW-1:0]  m0_creq_size, m1_creq_size;
   logic [IW-1:0]  m0_creq_id, m1_creq_id;
   logic [AW-1:0]  m0_creq_addr, m1_creq_addr;
   logic m0_creq_rdstall, m1_creq_rdstall, m0_creq_wrstall, m1_creq_wrstall;
   logic m0_dreq_valid, m1_dreq_valid;
   logic [IW-1:0]  m0_dreq_id, m1_dreq_id;
   logic [DW-1:0]  m0_dreq_data, m1_dreq_data;
   logic [ATW-1:0] m0_dreq_attr, m1_dreq_attr;
   logic m0_dreq_stall, m1_dreq_stall;
   logic m0_rreq_valid, m1_rreq_valid;
   logic [IW-1:0]  m0_rreq_id, m1_rreq_id;
   logic [DW-1:0]  m0_rreq_data, m1_rreq_data;
   logic [ATW-1:0] m0_rreq_attr, m1_rreq_attr;
   logic m0_rreq_stall, m1_rreq_stall;
   logic s_creq_valid;
   logic [TW-1:0]  s_creq_type;
   logic [ATW-1:0] s_creq_attr;
   logic [SW-1:0]  s_creq_size;
   logic [IW:0]    s_creq_id;
   logic [AW-1:0]  s_creq_addr;
   logic s_creq_rdstall, s_creq_wrstall;
   logic s_dreq_valid;
   logic [IW:0]    s_dreq_id;
   logic [DW-1:0]  s_dreq_data;
   logic [ATW-1:0] s_dreq_attr;
   logic s_dreq_stall;
   logic s_rreq_valid;
   logic [IW:0]    s_rreq_id;
   logic [DW-1:0]  s_rreq_data;
   logic [ATW-1:0] s_rreq_attr;
   logic s_rreq_stall;

   naxi_arb_2x1 dut (
      .clk(clk), .rst(rst),
      .m0_creq_valid(m0_creq_valid), .m0_creq_type(m0_creq_type), .m0_creq_attr(m0_creq_attr),
      .m0_creq_size(m0_creq_size), .m0_creq_id(m0_creq_id), .m0_creq_addr(m0_creq_addr),
      .m0_creq_rdstall(m0_creq_rdstall), .m0_creq_wrstall(m0_creq_wrstall),
      .m0_dreq_valid(m0_dreq_valid), .m0_dreq_id(m0_dreq_id), .m0_dreq_data(m0_dreq_data),
      .m0_dreq_attr(m0_dreq_attr), .m0_dreq_stall(m0_dreq_stall),
      .m0_rreq_valid(m0_rreq_valid), .m0_rreq_id(m0_rreq_id), .m0_rreq_data(m0_rreq_data),
      .m0_rreq_attr(m0_rreq_attr), .m0_rreq_stall(m0_rreq_stall),
      .m1_creq_valid(m1_creq_valid), .m1_creq_type(m1_creq_type), .m1_creq_attr(m1_creq_attr),
      .m1_creq_size(m1_creq_size), .m1_creq_id(m1_creq_id), .m1_creq_addr(m1_creq_addr),
      .m1_creq_rdstall(m1_creq_rdstall), .m1_creq_wrstall(m1_creq_wrstall),
      .m1_dreq_valid(m1_dreq_valid), .m1_dreq_id(m1_dreq_id), .m1_dreq_data(m1_dreq_data),
      .m1_dreq_attr(m1_dreq_attr), .m1_dreq_stall(m1_dreq_stall),
      .m1_rreq_valid(m1_rreq_valid), .m1_rreq_id(m1_rreq_id), .m1_rreq_data(m1_rreq_data),
      .m1_rreq_attr(m1_rreq_attr), .m1_rreq_stall(m1_rreq_stall),
      .s_creq_valid(s_creq_valid), .s_creq_type(s_creq_type), .s_creq_attr(s_creq_attr),
      .s_creq_size(s_creq_size), .s_creq_id(s_creq_id), .s_creq_addr(s_creq_addr),
      .s_creq_rdstall(s_creq_rdstall), .s_creq_wrstall(s_creq_wrstall),
      .s_dreq_valid(s_dreq_valid), .s_dreq_id(s_dreq_id), .s_dreq_data(s_dreq_data),
      .s_dreq_attr(s_dreq_attr), .s_dreq_stall(s_dreq_stall),
      .s_rreq_valid(s_rreq_valid), .s_rreq_id(s_rreq_id), .s_rreq_data(s_rreq_data),
      .s_rreq_attr(s_rreq_attr), .s_rreq_stall(s_rreq_stall)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Single comparison point for the whole bench.
   task automatic check_val(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Master-side stimulus state (commands are held until accepted).
   logic           cv [2];
   logic [TW-1:0]  ctype [2];
   logic [ATW-1:0] cattr [2];
   logic [SW-1:0]  csize [2];
   logic [IW-1:0]  cid [2];
   logic [AW-1:0]  caddr [2];
   logic           dv [2];
   logic [IW-1:0]  did [2];
   logic [DW-1:0]  ddata [2];
   logic [ATW-1:0] dattr [2];
   logic           mrstall [2];
   int             dprob;

   // Reference model: pointer, queue of outstanding write bursts, beats done.
   int rr;
   int q_src [$];
   int q_size [$];
   int beats;

   task automatic model_reset();
      rr = 0;
      q_src.delete();
      q_size.delete();
      beats = 0;
   endtask

   task automatic drive_ports();
      m0_creq_valid = cv[0]; m0_creq_type = ctype[0]; m0_creq_attr = cattr[0];
      m0_creq_size = csize[0]; m0_creq_id = cid[0]; m0_creq_addr = caddr[0];
      m1_creq_valid = cv[1]; m1_creq_type = ctype[1]; m1_creq_attr = cattr[1];
      m1_creq_size = csize[1]; m1_creq_id = cid[1]; m1_creq_addr = caddr[1];
      m0_dreq_valid = dv[0]; m0_dreq_id = did[0]; m0_dreq_data = ddata[0]; m0_dreq_attr = dattr[0];
      m1_dreq_valid = dv[1]; m1_dreq_id = did[1]; m1_dreq_data = ddata[1]; m1_dreq_attr = dattr[1];
      m0_rreq_stall = mrstall[0]; m1_rreq_stall = mrstall[1];
   endtask

   task automatic randomize_inputs();
      for (int n = 0; n < 2; n++) begin
         if (!cv[n] && ($urandom_range(0, 1) == 1)) begin
            cv[n]    = 1'b1;
            ctype[n] = ($urandom_range(0, 1) == 1) ? 3'd1 : TW'($urandom_range(0, 7));
            csize[n] = SW'($urandom_range(0, 3));
            cid[n]   = IW'($urandom);
            caddr[n] = AW'($urandom);
            cattr[n] = ATW'($urandom);
         end
         dv[n]      = ($urandom_range(0, 99) < dprob);
         did[n]     = IW'($urandom);
         ddata[n]   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         dattr[n]   = ATW'($urandom);
         mrstall[n] = ($urandom_range(0, 2) == 0);
      end
      s_creq_rdstall = ($urandom_range(0, 3) == 0);
      s_creq_wrstall = ($urandom_range(0, 3) == 0);
      s_dreq_stall   = ($urandom_range(0, 3) == 0);
      s_rreq_valid   = $urandom_range(0, 1) == 1;
      s_rreq_id      = (IW+1)'($urandom);
      s_rreq_data    = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      s_rreq_attr    = ATW'($urandom);
   endtask

   task automatic check_reset_outputs();
      check_val("rst_s_creq_valid", s_creq_valid, 1'b0);
      check_val("rst_s_dreq_valid", s_dreq_valid, 1'b0);
      check_val("rst_m0_rreq_valid", m0_rreq_valid, 1'b0);
      check_val("rst_m1_rreq_valid", m1_rreq_valid, 1'b0);
      check_val("rst_stalls", {m0_creq_rdstall, m0_creq_wrstall, m1_creq_rdstall, m1_creq_wrstall,
                               m0_dreq_stall, m1_dreq_stall, s_rreq_stall}, 7'h7f);
   endtask

   // One clock: drive at the falling edge, compare after settling, then advance the model.
   task automatic run_cycle();
      int  ms, h, k;
      logic selv, wr, full, ecv, cacc, dacc;
      logic o_rd [2], o_wr [2], o_ds [2], o_rv [2];
      logic [IW-1:0] o_rid [2];
      logic [DW-1:0] o_rdata [2];
      drive_ports();
      #1;
      o_rd = '{m0_creq_rdstall, m1_creq_rdstall};
      o_wr = '{m0_creq_wrstall, m1_creq_wrstall};
      o_ds = '{m0_dreq_stall, m1_dreq_stall};
      o_rv = '{m0_rreq_valid, m1_rreq_valid};
      o_rid = '{m0_rreq_id, m1_rreq_id};
      o_rdata = '{m0_rreq_data, m1_rreq_data};
      full = (q_src.size() == 4);
      ms = (cv[0] && !cv[1]) ? 0 : ((cv[1] && !cv[0]) ? 1 : rr);
      selv = cv[ms];
      wr = (ctype[ms] == 3'd1);
      ecv = selv && !(wr && full);
      check_val("s_creq_valid", s_creq_valid, ecv);
      if (selv) begin
         check_val("s_creq_id", s_creq_id, {(ms == 1), cid[ms]});
         check_val("s_creq_addr", s_creq_addr, caddr[ms]);
         check_val("s_creq_size", s_creq_size, csize[ms]);
         check_val("s_creq_type", s_creq_type, ctype[ms]);
         check_val("s_creq_attr", s_creq_attr, cattr[ms]);
      end
      for (int n = 0; n < 2; n++) begin
         check_val($sformatf("m%0d_creq_rdstall", n), o_rd[n], !(cv[n] && ms == n) || s_creq_rdstall);
         check_val($sformatf("m%0d_creq_wrstall", n), o_wr[n], !(cv[n] && ms == n) || s_creq_wrstall || full);
      end
      dacc = 1'b0;
      if (q_src.size() == 0) begin
         check_val("s_dreq_valid_empty", s_dreq_valid, 1'b0);
         check_val("dreq_stall_empty", {o_ds[0], o_ds[1]}, 2'b11);
      end else begin
         h = q_src[0];
         check_val("s_dreq_valid", s_dreq_valid, dv[h]);
         check_val("head_dreq_stall", o_ds[h], s_dreq_stall);
         check_val("other_dreq_stall", o_ds[1-h], 1'b1);
         check_val("s_dreq_id", s_dreq_id, {(h == 1), did[h]});
         check_val("s_dreq_data", s_dreq_data, ddata[h]);
         check_val("s_dreq_attr", s_dreq_attr, dattr[h]);
         dacc = dv[h] && !s_dreq_stall;
      end
      k = s_rreq_id[IW] ? 1 : 0;
      check_val("rreq_valid_sel", o_rv[k], s_rreq_valid);
      check_val("rreq_valid_other", o_rv[1-k], 1'b0);
      check_val("s_rreq_stall", s_rreq_stall, mrstall[k]);
      check_val("rreq_id", o_rid[k], s_rreq_id[IW-1:0]);
      check_val("rreq_data", o_rdata[k], s_rreq_data);
      cacc = ecv && !(wr ? s_creq_wrstall : s_creq_rdstall);
      @(posedge clk);
      if (dacc) begin
         beats++;
         if (beats == q_size[0] + 1) begin
            void'(q_src.pop_front());
            void'(q_size.pop_front());
            beats = 0;
         end
      end
      if (cacc) begin
         rr = 1 - ms;
         if (wr) begin
            q_src.push_back(ms);
            q_size.push_back(int'(csize[ms]));
         end
         cv[ms] = 1'b0;
      end
      @(negedge clk);
   endtask

   initial begin
      for (int n = 0; n < 2; n++) begin
         cv[n] = 1'b0; ctype[n] = '0; cattr[n] = '0; csize[n] = '0; cid[n] = '0; caddr[n] = '0;
      end
      dprob = 70;
      model_reset();
      rst = 1'b0;
      randomize_inputs();
      cv[0] = 1'b1; cv[1] = 1'b1; dv[0] = 1'b1; dv[1] = 1'b1; s_rreq_valid = 1'b1;
      drive_ports();
      #1;
      check_reset_outputs();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;

      // Round-robin with both masters reading continuously, slave never stalled.
      for (int i = 0; i < 4; i++) begin
         randomize_inputs();
         cv[0] = 1'b1; cv[1] = 1'b1; ctype[0] = 3'd0; ctype[1] = 3'd2;
         s_creq_rdstall = 1'b0; s_creq_wrstall = 1'b0;
         drive_ports();
         #1;
         check_val("rr_alternate", s_creq_id[IW], (i % 2));
         run_cycle();
      end

      for (int c = 0; c < 600; c++) begin
         dprob = (c < 200) ? 70 : ((c < 400) ? 10 : 90);
         randomize_inputs();
         if (c == 300) begin
            // Asynchronous reset in the middle of traffic.
            cv[0] = 1'b1; cv[1] = 1'b1; dv[0] = 1'b1; dv[1] = 1'b1; s_rreq_valid = 1'b1;
            drive_ports();
            #2;
            rst = 1'b0;
            #1;
            check_reset_outputs();
            @(posedge clk);
            @(negedge clk);
            rst = 1'b1;
            model_reset();
         end
         run_cycle();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
